// File: rtl/wr_resp_q.sv
// rtl/wr_resp_q.sv - queued opcode-response framer for uart_tx; define WR_RESP_CKSUM_EN for a checksum byte
module wr_resp_q #(
    parameter logic [7:0] MATCH_VAL  = 8'h10,
    parameter logic [7:0] MATCH_MASK = 8'hF0,
    parameter int         QDEPTH     = 4,
    parameter int         GAP_CYC    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 opcode,
    input  logic                       en,
    output logic [7:0]                 tx_data,
    output logic                       tx_en,
    input  logic                       tx_busy,
    output logic [$clog2(QDEPTH):0]    q_level,
    output logic                       busy,
    output logic                       ovf
);

    localparam int AW = $clog2(QDEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GAP_CYC + 1);
`ifdef WR_RESP_CKSUM_EN
    localparam int LEN = 3;
`else
    localparam int LEN = 2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [QDEPTH];
    logic [7:0]      mem_d [QDEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      op_q, op_d, seq_q, seq_d, tx_data_q, tx_data_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            ovf_q, ovf_d;
    logic            match, full, empty, push, pop;
    logic [7:0]      cur_byte;

    assign match = en && ((opcode & MATCH_MASK) == (MATCH_VAL & MATCH_MASK));
    assign full  = (level_q == LW'(QDEPTH));
    assign empty = (level_q == '0);
    assign pop   = (state_q == S_IDLE) && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push  = match && (!full || pop);

    // Queue bookkeeping: storage write, pointer advance, level and overflow pulse.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = match && full && !pop;
        if (push) begin
            mem_d[wr_ptr_q] = opcode;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // Byte of the current frame selected by byte_idx.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx_q)
            2'd0:    cur_byte = op_q;
            2'd1:    cur_byte = seq_q;
`ifdef WR_RESP_CKSUM_EN
            2'd2:    cur_byte = op_q ^ seq_q ^ 8'hA5;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    // Frame sender: pop, load byte, wait for a free UART, strobe, then hold off for the gap.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        seq_d      = seq_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        tx_data_d  = tx_data_q;
        tx_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    op_d       = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d = cur_byte;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_en     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                // tx_busy may lag the strobe, so it is not looked at here.
                if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
                    if (byte_idx_q < 2'(LEN - 1)) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_LOAD;
                    end else begin
                        seq_d   = seq_q + 8'd1;
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Queue storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            op_q       <= 8'h00;
            seq_q      <= 8'h00;
            byte_idx_q <= 2'd0;
            gap_cnt_q  <= '0;
            tx_data_q  <= 8'h00;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            op_q       <= op_d;
            seq_q      <= seq_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_data_q  <= tx_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx_data = tx_data_q;
    assign q_level = level_q;
    assign busy    = !empty || (state_q != S_IDLE);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_wr_resp_q.sv
// tb/tb_wr_resp_q.sv - self-checking bench for wr_resp_q with a frame-level reference model
module tb_wr_resp_q;

`ifdef WR_RESP_CKSUM_EN
    localparam int LEN = 3;
`else
    localparam int LEN = 2;
`endif

    logic       clk = 1'b0;
    logic       rst, en, tx_en, tx_busy, busy, ovf;
    logic [7:0] opcode, tx_data;
    logic [2:0] q_level;

    always #5 clk = ~clk;

    wr_resp_q dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .en      (en),
        .tx_data (tx_data),
        .tx_en   (tx_en),
        .tx_busy (tx_busy),
        .q_level (q_level),
        .busy    (busy),
        .ovf     (ovf)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] cap[$];
    logic [7:0] expq[$];
    int         strobe_cyc[$];
    int         busy_len_q[$];
    logic [7:0] exp_seq = 8'h00;
    int         ovf_cnt = 0;
    int         proto_err = 0;
    int         cyc = 0;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;
    logic       prev_tx_en = 1'b0;

    // UART model and monitor: records strobed bytes, holds busy for a while after each strobe.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_en) begin
                cap.push_back(tx_data);
                strobe_cyc.push_back(cyc);
                if (tx_busy) proto_err++;
                if (prev_tx_en) proto_err++;
                busy_cnt = (busy_len_q.size() > 0) ? busy_len_q.pop_front() : int'($urandom_range(0, 3));
            end
            if (ovf) ovf_cnt++;
            prev_tx_en = tx_en;
            @(posedge clk);
            #1;
            if (busy_cnt > 0) begin
                tx_busy = 1'b1;
                busy_cnt--;
            end else begin
                tx_busy = force_busy;
            end
        end
    end

    function automatic logic model_match(input logic [7:0] op);
        return (op & 8'hF0) == 8'h10;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [7:0] op, input logic [7:0] sq, input int i);
        if (i == 0) return op;
        if (i == 1) return sq;
        return op ^ sq ^ 8'hA5;
    endfunction

    task automatic expect_frame(input logic [7:0] op);
        for (int i = 0; i < LEN; i++) expq.push_back(frame_byte(op, exp_seq, i));
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op);
        opcode = op;
        en = 1'b1;
        if (model_match(op)) expect_frame(op);
        tick();
        en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        opcode = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        cap.delete();
        expq.delete();
        strobe_cyc.delete();
        exp_seq = 8'h00;
        ovf_cnt = 0;
    endtask

    task automatic wait_idle(input int budget);
        logic done = 1'b0;
        tick();
        tick();
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (!busy && busy_cnt == 0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy=%0b still set after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic check_frames(input string name);
        n_cmp++;
        if (cap.size() !== expq.size()) begin
            n_bad++;
            $display("FAIL %s byte_count: got %0d required %0d", name, cap.size(), expq.size());
        end else begin
            for (int i = 0; i < expq.size(); i++) begin
                n_cmp++;
                if (cap[i] !== expq[i]) begin
                    n_bad++;
                    $display("FAIL %s byte[%0d]: got %02h required %02h", name, i, cap[i], expq[i]);
                end
            end
        end
        cap.delete();
        expq.delete();
        strobe_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        opcode = 8'h00;
        tick();
        tick();
        @(negedge clk);
        n_cmp += 5;
        if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %02h required 00", tx_data); end
        if (tx_en !== 1'b0)    begin n_bad++; $display("FAIL reset_tx_en: got %0b required 0", tx_en); end
        if (q_level !== 3'd0)  begin n_bad++; $display("FAIL reset_q_level: got %0d required 0", q_level); end
        if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
        if (ovf !== 1'b0)      begin n_bad++; $display("FAIL reset_ovf: got %0b required 0", ovf); end
        do_reset();
    endtask

    task automatic test_latency_seq();
        int first = -1;
        do_reset();
        tick();
        opcode = 8'h13;
        en = 1'b1;
        expect_frame(8'h13);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx_en && first < 0) first = k;
            @(posedge clk);
            #1;
            en = 1'b0;
        end
        n_cmp++;
        if (first !== 3) begin
            n_bad++;
            $display("FAIL latency: first tx_en %0d cycles after en cycle, required 3", first);
        end
        wait_idle(200);
        issue(8'h1F);
        wait_idle(200);
        check_frames("latency_seq");
    endtask

    task automatic test_nonmatch();
        logic       saw_busy = 1'b0;
        logic [7:0] op;
        do_reset();
        tick();
        issue(8'h23);
        for (int i = 0; i < 8; i++) begin
            op = 8'($urandom);
            if (op[7:4] == 4'h1) op[7:4] = 4'h3;
            issue(op);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        n_cmp += 2;
        if (saw_busy !== 1'b0) begin n_bad++; $display("FAIL nonmatch_busy: got %0b required 0", saw_busy); end
        if (cap.size() !== 0)  begin n_bad++; $display("FAIL nonmatch_tx: got %0d bytes required 0", cap.size()); end
        tick();
        issue(8'h1F);
        wait_idle(200);
        check_frames("mask_accept");
    endtask

    task automatic test_overflow();
        do_reset();
        force_busy = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) issue({4'h1, 4'($urandom_range(0, 15))});
        n_cmp++;
        if (ovf_cnt !== 0) begin n_bad++; $display("FAIL ovf_early: got %0d pulses required 0", ovf_cnt); end
        opcode = 8'h1A;
        en = 1'b1;
        tick();
        en = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (ovf !== 1'b1)     begin n_bad++; $display("FAIL ovf_pulse: got %0b required 1", ovf); end
        if (q_level !== 3'd4) begin n_bad++; $display("FAIL ovf_level: got %0d required 4", q_level); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_one_cycle: got %0b required 0", ovf); end
        force_busy = 1'b0;
        wait_idle(500);
        n_cmp++;
        if (ovf_cnt !== 1) begin n_bad++; $display("FAIL ovf_count: got %0d required 1", ovf_cnt); end
        check_frames("overflow");
    endtask

    task automatic test_holdoff();
        int gap = -1;
        do_reset();
        busy_len_q.push_back(20);
        tick();
        issue(8'h15);
        wait_idle(500);
        if (strobe_cyc.size() >= 2) gap = strobe_cyc[1] - strobe_cyc[0];
        n_cmp++;
        if (gap !== 21) begin
            n_bad++;
            $display("FAIL holdoff_gap: got %0d cycles between strobes required 21", gap);
        end
        check_frames("holdoff");
    endtask

    task automatic test_reset_midframe();
        logic found = 1'b0;
        logic dirty = 1'b0;
        int   n0;
        do_reset();
        busy_len_q.push_back(20);
        tick();
        opcode = 8'h11; en = 1'b1; tick();
        opcode = 8'h12; tick();
        opcode = 8'h13; tick();
        en = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (tx_en) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL midframe_strobe: got no tx_en required one"); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n0 = cap.size();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (q_level != 0 || busy) dirty = 1'b1;
        end
        n_cmp += 2;
        if (cap.size() !== n0) begin n_bad++; $display("FAIL midframe_tx: got %0d bytes required %0d", cap.size(), n0); end
        if (dirty !== 1'b0)    begin n_bad++; $display("FAIL midframe_flush: got busy/level set required clear"); end
        wait_idle(100);
        cap.delete();
        expq.delete();
        exp_seq = 8'h00;
        issue(8'h1C);
        wait_idle(200);
        check_frames("midframe_seq");
    endtask

    task automatic test_random();
        logic [7:0] op;
        int         nm;
        do_reset();
        for (int b = 0; b < 40; b++) begin
            nm = 0;
            for (int j = 0; j < int'($urandom_range(1, 8)); j++) begin
                op = ($urandom_range(0, 1) == 1) ? {4'h1, 4'($urandom_range(0, 15))} : 8'($urandom);
                if (model_match(op)) begin
                    if (nm == 5) op = op ^ 8'h80;
                    else nm++;
                end
                issue(op);
                repeat (int'($urandom_range(0, 2))) tick();
            end
            wait_idle(400);
            check_frames("random");
        end
        n_cmp++;
        if (ovf_cnt !== 0) begin n_bad++; $display("FAIL random_ovf: got %0d pulses required 0", ovf_cnt); end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        for (int f = 0; f < 260; f++) begin
            issue({4'h1, 4'($urandom_range(0, 15))});
            if (f % 4 == 3) begin
                wait_idle(400);
                check_frames("seq_wrap");
            end
        end
    endtask

    task automatic test_protocol();
        n_cmp++;
        if (proto_err !== 0) begin
            n_bad++;
            $display("FAIL protocol: got %0d tx_en violations required 0", proto_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        opcode = 8'h00;
        test_reset();
        test_latency_seq();
        test_nonmatch();
        test_overflow();
        test_holdoff();
        test_reset_midframe();
        test_random();
        test_seq_wrap();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
